// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage ahead of decode. Owns the fetch PC, presents it to the
//   instruction memory, captures the combinational instruction word into a
//   small FIFO and hands {instr, pc} to decode over valid/ready. A redirect
//   from decode/execute reloads the fetch PC and flushes buffered fetches.
//
// Ports
//   clk            in   system clock, all state on the rising edge
//   rst_n          in   asynchronous active-low reset
//   inst_addr      out  instruction memory address (= fetch PC, registered)
//   instr          in   instruction word read combinationally from inst_addr
//   redirect_valid in   load redirect_pc into the fetch PC, flush the buffer
//   redirect_pc    in   redirect target; bits [1:0] are ignored
//   out_valid      out  out_instr/out_pc hold a valid entry
//   out_ready      in   decode accepts the entry this cycle
//   out_instr      out  head-of-FIFO instruction (0 when empty)
//   out_pc         out  PC of out_instr (0 when empty)
//   fetch_count    out  number of delivered instructions, wraps at 2^32
//
// Handshake: an entry transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready low, out_* hold steady; out_valid
// only drops after a transfer or because of a redirect.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_WIDTH-1:0]  inst_addr,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [31:0]            fetch_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]           r_wr_ptr;
    logic [PTR_W:0]           r_rd_ptr;
    logic [ADDR_WIDTH-1:0]    r_fetch_pc;
    logic [31:0]              r_fetch_count;
    logic [INSTR_WIDTH-1:0]   r_buf_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]    r_buf_pc    [FIFO_DEPTH];

    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic [PTR_W:0]           w_rd_ptr_next;
    logic [ADDR_WIDTH-1:0]    w_redirect_target;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_pop  = !w_empty && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = !redirect_valid && (!w_full || w_pop);

    assign w_rd_ptr_next = r_rd_ptr + {{PTR_W{1'b0}}, w_pop};

    // Targets are word aligned; the low two bits are simply masked off.
    assign w_redirect_target = redirect_pc & ~ADDR_WIDTH'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fetch_pc    <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                // Drop everything behind the entry (if any) that handshakes
                // this cycle by collapsing the write pointer onto the read
                // pointer; that cycle's fetch is discarded as well.
                r_wr_ptr   <= w_rd_ptr_next;
                r_fetch_pc <= w_redirect_target;
            end else if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
            end
        end
    end

    // Storage needs no reset: entries are only observed while the FIFO
    // reports them as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr[PTR_W-1:0]] <= instr;
            r_buf_pc[r_wr_ptr[PTR_W-1:0]]    <= r_fetch_pc;
        end
    end

    assign inst_addr   = r_fetch_pc;
    assign out_valid   = !w_empty;
    assign out_instr   = w_empty ? '0 : r_buf_instr[r_rd_ptr[PTR_W-1:0]];
    assign out_pc      = w_empty ? '0 : r_buf_pc[r_rd_ptr[PTR_W-1:0]];
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int          AW       = 32;
  localparam int          IW       = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'h0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] inst_addr;
  logic [IW-1:0] instr;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [31:0]   fetch_count;

  instruction_fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_addr     (inst_addr),
    .instr         (instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_count   (fetch_count)
  );

  // instruction memory: every word is a scrambled function of its address
  logic [31:0] salt = 32'h0;
  assign instr = (inst_addr * 32'h9E3779B1) ^ salt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  // reference model: stream of fetched PCs awaiting delivery
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_count;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RST_PC;
    m_count = 0;
  endtask

  // compare all outputs against the model's current view
  task automatic check_outputs(input string where);
    check_eq({where, ":inst_addr"}, inst_addr, m_pc);
    check_eq({where, ":fetch_count"}, fetch_count, m_count);
    check_eq({where, ":out_valid"}, {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      check_eq({where, ":out_pc"}, out_pc, exp_q[0]);
      check_eq({where, ":out_instr"}, out_instr, mem_word(exp_q[0]));
    end
  endtask

  // one clock: drive inputs, check, clock, advance model
  task automatic step(input string where, input logic redir, input logic [31:0] rpc,
                      input logic rdy);
    logic pop;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    check_outputs(where);
    @(posedge clk);
    pop = (exp_q.size() > 0) && rdy;
    if (pop) begin
      void'(exp_q.pop_front());
      m_count++;
    end
    if (redir) begin
      exp_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(m_pc);
      m_pc += 32'd4;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    model_reset();
    check_eq("rst:out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst:inst_addr", inst_addr, RST_PC);
    check_eq("rst:fetch_count", fetch_count, 32'd0);
    check_eq("rst:out_pc", out_pc, 32'd0);
    check_eq("rst:out_instr", out_instr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    salt = $urandom;
    model_reset();
    apply_reset();

    // 1: streaming from reset, one per cycle
    for (int i = 0; i < 4; i++) step("t1", 1'b0, 32'h0, 1'b1);
    check_eq("t1:count_after3", fetch_count, 32'd3);

    // 2: stall after reset, FIFO holds 0,4 and PC parks at 8
    apply_reset();
    for (int i = 0; i < 4; i++) step("t2stall", 1'b0, 32'h0, 1'b0);
    check_eq("t2:inst_addr_parked", inst_addr, 32'h8);
    check_eq("t2:head_pc", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) step("t2drain", 1'b0, 32'h0, 1'b1);

    // 3: full FIFO, redirect with a simultaneous handshake
    apply_reset();
    for (int i = 0; i < 3; i++) step("t3fill", 1'b0, 32'h0, 1'b0);
    step("t3redir", 1'b1, 32'h40, 1'b1);
    check_eq("t3:count_after_redir", fetch_count, 32'd1);
    check_eq("t3:valid_gap", {31'b0, out_valid}, 32'd0);
    step("t3a", 1'b0, 32'h0, 1'b1);
    check_eq("t3:target_pc", out_pc, 32'h40);
    step("t3b", 1'b0, 32'h0, 1'b1);

    // 4: unaligned target
    step("t4redir", 1'b1, 32'h43, 1'b0);
    check_eq("t4:inst_addr", inst_addr, 32'h40);
    step("t4a", 1'b0, 32'h0, 1'b1);
    check_eq("t4:target_pc", out_pc, 32'h40);

    // 5: wrap at top of address space
    step("t5redir", 1'b1, 32'hFFFF_FFFC, 1'b1);
    step("t5a", 1'b0, 32'h0, 1'b1);
    check_eq("t5:top_pc", out_pc, 32'hFFFF_FFFC);
    step("t5b", 1'b0, 32'h0, 1'b1);
    check_eq("t5:wrapped_pc", out_pc, 32'h0);

    // 6: reset mid-stream with a full FIFO
    for (int i = 0; i < 3; i++) step("t6fill", 1'b0, 32'h0, 1'b0);
    check_eq("t6:full_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    apply_reset();
    step("t6post", 1'b0, 32'h0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [31:0] t;
      r = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: t = $urandom_range(0, 255);
        1: t = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: t = $urandom;
      endcase
      step("rand", r, t, $urandom_range(0, 9) < 7);
    end
    step("final", 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
